// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: PC generation, instruction-memory request
// handshake and a DEPTH-entry {pc, inst} queue feeding the IF/ID register.
// Decouples fetch from decode stalls and presents NOP bubbles when empty or
// while a redirect is flushing the queue.
module inst_fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter logic [ILEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [XLEN-1:0]              imem_addr,
    output logic                         imem_req,
    input  logic                         imem_ready,
    input  logic [ILEN-1:0]              imem_rdata,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic                         deq_stall,
    output logic                         out_valid,
    output logic [ILEN-1:0]              out_inst,
    output logic [XLEN-1:0]              out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    // Queue storage; contents are only meaningful where count says so,
    // so it carries no reset.
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [ILEN-1:0] inst_mem [DEPTH];

    logic fetch;
    logic deq;
    logic queue_full;
    logic queue_empty;

    // Handshake and dequeue qualifiers; redirect overrides both sides.
    always_comb begin
        queue_full  = (count_q == CW'(DEPTH));
        queue_empty = (count_q == '0);
        imem_req    = !queue_full;
        imem_addr   = fetch_pc;
        fetch       = imem_req && imem_ready && !redirect;
        out_valid   = !queue_empty && !redirect;
        deq         = out_valid && !deq_stall;
        count       = count_q;
    end

    // Head presentation: bubble whenever nothing valid is offered.
    always_comb begin
        out_inst = NOP_INST;
        out_pc   = '0;
        if (out_valid) begin
            out_inst = inst_mem[rd_ptr];
            out_pc   = pc_mem[rd_ptr];
        end
    end

    // Write fetched pair at the tail.
    always_ff @(posedge clk) begin
        if (fetch) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

    // Fetch PC: reset vector, redirect target (word aligned) or sequential.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (fetch) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // Pointers and occupancy; redirect flushes the whole queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (fetch) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({fetch, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: sequential fetch, stall/backpressure,
// redirect flush, imem wait states, PC wrap and asynchronous reset.
module tb_inst_fetch_queue;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ready;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_stall;
    logic            out_valid;
    logic [ILEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      count;

    logic            rst2_n;
    logic [XLEN-1:0] imem_addr2;
    logic            imem_req2;
    logic [ILEN-1:0] imem_rdata2;
    logic            out_valid2;
    logic [ILEN-1:0] out_inst2;
    logic [XLEN-1:0] out_pc2;
    logic [2:0]      count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word derived from its address.
    function automatic logic [ILEN-1:0] inst_of(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata  = inst_of(imem_addr);
    assign imem_rdata2 = inst_of(imem_addr2);

    inst_fetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_stall(deq_stall),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .count(count)
    );

    inst_fetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst2_n),
        .imem_addr(imem_addr2), .imem_req(imem_req2),
        .imem_ready(1'b1), .imem_rdata(imem_rdata2),
        .redirect(1'b0), .redirect_pc(64'h0),
        .deq_stall(1'b0),
        .out_valid(out_valid2), .out_inst(out_inst2), .out_pc(out_pc2),
        .count(count2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rst2_n      = 1'b0;
        imem_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        deq_stall   = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_inst",  64'(out_inst), 64'h13);
        chk("rst_pc",    out_pc, 64'd0);
        chk("rst_addr",  imem_addr, 64'd0);
        chk("rst_req",   64'(imem_req), 64'd1);

        // 1: free-running fetch, one entry in flight
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t1_valid", 64'(out_valid), 64'd1);
            chk("t1_pc",    out_pc, 64'(4*(i-1)));
            chk("t1_inst",  64'(out_inst), 64'(inst_of(64'(4*(i-1)))));
            chk("t1_count", 64'(count), 64'd1);
            chk("t1_addr",  imem_addr, 64'(4*i));
        end

        // 2: stall until full, then drain without gaps
        rst_n = 1'b0;
        #1;
        rst_n     = 1'b1;
        deq_stall = 1'b1;
        repeat (4) @(negedge clk);
        chk("t2_count_full", 64'(count), 64'd4);
        chk("t2_req_off",    64'(imem_req), 64'd0);
        chk("t2_addr",       imem_addr, 64'h10);
        @(negedge clk);
        chk("t2_addr_held",  imem_addr, 64'h10);
        chk("t2_count_held", 64'(count), 64'd4);
        deq_stall = 1'b0;
        #1;
        chk("t2_pc0", out_pc, 64'h0);
        @(negedge clk); chk("t2_pc4", out_pc, 64'h4);
        @(negedge clk); chk("t2_pc8", out_pc, 64'h8);
        @(negedge clk); chk("t2_pcc", out_pc, 64'hC);
        @(negedge clk); chk("t2_pc10", out_pc, 64'h10);
        chk("t2_valid", 64'(out_valid), 64'd1);

        // 3: redirect with a full queue
        deq_stall = 1'b1;
        @(negedge clk);
        chk("t3_full", 64'(count), 64'd4);
        redirect    = 1'b1;
        redirect_pc = 64'h1002;
        #1;
        chk("t3_nop_valid", 64'(out_valid), 64'd0);
        chk("t3_nop_inst",  64'(out_inst), 64'h13);
        @(negedge clk);
        redirect  = 1'b0;
        deq_stall = 1'b0;

        // 4: imem wait states with an empty queue
        imem_ready = 1'b0;
        #1;
        chk("t3_count0", 64'(count), 64'd0);
        chk("t3_addr",   imem_addr, 64'h1000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("t4_addr",  imem_addr, 64'h1000);
            chk("t4_valid", 64'(out_valid), 64'd0);
            chk("t4_inst",  64'(out_inst), 64'h13);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        chk("t3_pc1000", out_pc, 64'h1000);
        chk("t3_inst",   64'(out_inst), 64'(inst_of(64'h1000)));
        @(negedge clk);
        chk("t4_pc1004", out_pc, 64'h1004);

        // 6: asynchronous reset with three entries queued
        deq_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_count3", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_inst",  64'(out_inst), 64'h13);
        chk("t6_pc",    out_pc, 64'd0);
        chk("t6_addr",  imem_addr, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        deq_stall = 1'b0;
        @(negedge clk);
        chk("t6_first_pc",  out_pc, 64'd0);
        chk("t6_first_val", 64'(out_valid), 64'd1);

        // 5: PC wrap from a high reset vector
        rst2_n = 1'b1;
        #1;
        chk("t5_addr0", imem_addr2, 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk);
        chk("t5_addr1", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_pc1",   out_pc2, 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk);
        chk("t5_addr2", imem_addr2, 64'h0);
        chk("t5_pc2",   out_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        chk("t5_addr3", imem_addr2, 64'h4);
        chk("t5_pc3",   out_pc2, 64'h0);
        chk("t5_inst3", 64'(out_inst2), 64'(inst_of(64'h0)));
        @(negedge clk);
        chk("t5_pc4",   out_pc2, 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
